shift_normalizer: RTL and testbench

- Sequential inverse of the team's logical barrel shifter: it takes an N-bit word and finds the shift that normalizes it, instead of applying a given shift.
- Direction 0 (left): counts leading zeros, left-shifts until the MSB is 1.
- Direction 1 (right): counts trailing zeros, right-shifts until the LSB is 1.
- Iterative binary-search datapath, one stage per cycle, with valid/ready handshakes on both sides.
- Sits in front of the barrel shifter. Feeding data_out, shift_amt and the opposite direction back through the barrel shifter reproduces the original word.

---
 rtl/shift_normalizer.sv | 142 ++++++++++++++
 tb/tb_shift_normalizer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_normalizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | shift_normalizer: iterative leading/trailing-zero normalizer             |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module shift_normalizer #(
    parameter  int N = 8,
    localparam int L = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] data_in,
    input  logic         shift_dir,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] data_out,
    output logic [L-1:0] shift_amt,
    output logic         is_zero
);

    localparam logic [L-1:0] c_half = L'(N / 2);
    localparam logic [L-1:0] c_last = L'(L - 1);
    localparam logic [N-1:0] c_ones = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_accept;
    logic           w_last;

    logic [N-1:0]   r_work;
    logic [L-1:0]   r_cnt;
    logic [L-1:0]   r_k;
    logic           r_dir;
    logic           r_zero;

    logic           r_in_ready;
    logic           r_out_valid;
    logic [N-1:0]   r_data_out;
    logic [L-1:0]   r_shift_amt;
    logic           r_is_zero;

    logic [L-1:0]   w_w;
    logic [N-1:0]   w_mask_hi;
    logic [N-1:0]   w_mask_lo;
    logic           w_hit;
    logic [N-1:0]   w_work_nxt;
    logic [L-1:0]   w_cnt_nxt;

    // Stage width halves every cycle: N/2, N/4, ..., 1.
    assign w_w        = c_half >> r_k;
    assign w_mask_hi  = ~(c_ones >> w_w);
    assign w_mask_lo  = ~(c_ones << w_w);
    assign w_hit      = r_dir ? ((r_work & w_mask_lo) == '0)
                              : ((r_work & w_mask_hi) == '0);
    assign w_work_nxt = !w_hit ? r_work : (r_dir ? (r_work >> w_w) : (r_work << w_w));
    assign w_cnt_nxt  = w_hit ? (r_cnt + w_w) : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (r_k == c_last) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work      <= '0;
            r_cnt       <= '0;
            r_k         <= '0;
            r_dir       <= 1'b0;
            r_zero      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
            r_shift_amt <= '0;
            r_is_zero   <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_work <= data_in;
                r_dir  <= shift_dir;
                r_cnt  <= '0;
                r_k    <= '0;
                r_zero <= (data_in == '0);
            end else if (r_state == S_SEARCH) begin
                r_work <= w_work_nxt;
                r_cnt  <= w_cnt_nxt;
                r_k    <= r_k + 1'b1;
            end
            // An all-zero word would otherwise report a count of N-1.
            if (w_last) begin
                r_data_out  <= r_zero ? '0 : w_work_nxt;
                r_shift_amt <= r_zero ? '0 : w_cnt_nxt;
                r_is_zero   <= r_zero;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;
    assign shift_amt = r_shift_amt;
    assign is_zero   = r_is_zero;

endmodule
`default_nettype wire

// File: tb/tb_shift_normalizer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_shift_normalizer: scoreboard bench for shift_normalizer (N=8)          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_shift_normalizer;

    localparam int N = 8;
    localparam int L = 3;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         shift_dir = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] data_in   = '0;
    logic         in_ready;
    logic         out_valid;
    logic [N-1:0] data_out;
    logic [L-1:0] shift_amt;
    logic         is_zero;

    shift_normalizer #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shift_dir (shift_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .shift_amt (shift_amt),
        .is_zero   (is_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] orig;
        logic         dir;
        logic [N-1:0] dout;
        logic [L-1:0] amt;
        logic         zero;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: shift one bit at a time until normalized.
    function automatic exp_t model(input logic [N-1:0] d, input logic dir);
        exp_t         e;
        logic [N-1:0] t;
        int           c;
        t      = d;
        c      = 0;
        e.orig = d;
        e.dir  = dir;
        if (d == '0) begin
            e.dout = '0;
            e.amt  = '0;
            e.zero = 1'b1;
        end else begin
            while (dir ? !t[0] : !t[N-1]) begin
                t = dir ? (t >> 1) : (t << 1);
                c++;
            end
            e.dout = t;
            e.amt  = L'(c);
            e.zero = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [N-1:0] bshift(input logic [N-1:0] d, input logic [L-1:0] amt,
                                            input logic dir);
        return dir ? (d >> amt) : (d << amt);
    endfunction

    task automatic send(input logic [N-1:0] d, input logic dir);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 32'(guard < 50), 32'd1);
        in_valid  = 1'b1;
        data_in   = d;
        shift_dir = dir;
        sb.push_back(model(d, dir));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        data_in   = N'($urandom);
        shift_dir = 1'($urandom);
    endtask

    task automatic recv(input int bp, input bit rnd_ready);
        int           edges;
        exp_t         e;
        logic [N-1:0] hd;
        logic [L-1:0] ha;
        logic         hz;
        edges = 0;
        while (!out_valid && edges < 20) begin
            if (rnd_ready) out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            edges++;
        end
        out_ready = 1'b0;
        check("out_valid_wait", 32'(out_valid), 32'd1);
        check("latency", 32'(edges), 32'd3);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("data_out", 32'(data_out), 32'(e.dout));
            check("shift_amt", 32'(shift_amt), 32'(e.amt));
            check("is_zero", 32'(is_zero), 32'(e.zero));
            if (!e.zero) begin
                check("norm_bit", 32'(e.dir ? data_out[0] : data_out[N-1]), 32'd1);
                check("round_trip", 32'(bshift(data_out, shift_amt, ~e.dir)), 32'(e.orig));
            end
        end
        check("in_ready_busy", 32'(in_ready), 32'd0);
        hd = data_out;
        ha = shift_amt;
        hz = is_zero;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            check("hold", 32'({out_valid, in_ready, data_out, shift_amt, is_zero}),
                  32'({1'b1, 1'b0, hd, ha, hz}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("retire_valid", 32'(out_valid), 32'd0);
        check("retire_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_shift_amt", 32'(shift_amt), 32'd0);
        check("rst_is_zero", 32'(is_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_release_ready", 32'(in_ready), 32'd1);

        send(8'b0001_0110, 1'b0); recv(0, 1'b0);
        send(8'b0110_1000, 1'b1); recv(0, 1'b0);
        send(8'h01, 1'b0);        recv(0, 1'b0);
        send(8'h80, 1'b1);        recv(0, 1'b0);
        send(8'h00, 1'b0);        recv(0, 1'b0);
        send(8'h00, 1'b1);        recv(0, 1'b0);
        send(8'h80, 1'b0);        recv(0, 1'b0);
        send(8'h01, 1'b1);        recv(0, 1'b0);

        send(8'b0001_0110, 1'b0); recv(10, 1'b0);

        // Reset during the second search cycle discards the word.
        send(8'h16, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_data_out", 32'(data_out), 32'd0);
        check("midrst_shift_amt", 32'(shift_amt), 32'd0);
        check("midrst_is_zero", 32'(is_zero), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_valid", 32'(out_valid), 32'd0);
        end
        send(8'h2C, 1'b0); recv(0, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            send(N'($urandom), 1'($urandom));
            recv(int'($urandom_range(0, 3)), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
